// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op encodings and FSM state type for the stack command front-end
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    RSP     = 2'b10
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - PUSH/POP command front-end owning the stack pointer of the storage block
// Optional STACK_CTRL_PEEK_EN: op 11 reads the top entry without moving the pointer.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  output logic [DEPTH-1:0] stk_pointer,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             err_overflow,
  output logic             err_underflow,
  input  logic             err_clr
);

  localparam logic [DEPTH-1:0] PTR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [DEPTH-1:0] ptr_q, ptr_d;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             ovf_q, unf_q;

  op_e  op;
  logic accept, push_acc, pop_acc, is_peek;
  logic set_ovf, set_unf;

  assign op = op_e'(cmd_op);

`ifdef STACK_CTRL_PEEK_EN
  assign is_peek = (op == OP_PEEK);
`else
  assign is_peek = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign push_acc  = accept && (op == OP_PUSH);
  assign pop_acc   = accept && ((op == OP_POP) || is_peek);

  assign stk_push    = push_acc && !stk_full;
  assign stk_pop     = pop_acc && !stk_empty;
  assign stk_data_in = cmd_data;
  assign stk_pointer = ptr_q;

  assign set_ovf = push_acc && stk_full;
  assign set_unf = pop_acc && stk_empty;

  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

  // Peek reads the top entry but leaves the pointer where it is.
  always_comb begin
    ptr_d = ptr_q;
    if (stk_push) begin
      ptr_d = ptr_q + PTR_ONE;
    end else if (stk_pop && !is_peek) begin
      ptr_d = ptr_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= set_ovf | (ovf_q & ~err_clr);
      unf_q <= set_unf | (unf_q & ~err_clr);
      case (state_q)
        IDLE: begin
          if (pop_acc) begin
            if (stk_empty) begin
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RSP;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          // Storage read data is registered, so it lands one cycle after the pop strobe.
          rsp_data_q  <= stk_data_out;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - vector table plus response scoreboard for stack_ctrl with a storage model
module tb_stack_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_data_in;
  logic [DEPTH-1:0] stk_pointer;
  logic [WIDTH-1:0] stk_data_out = '0;
  logic             stk_full, stk_empty;
  logic             err_overflow, err_underflow;
  logic             err_clr = 1'b0;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_pointer(stk_pointer), .stk_data_out(stk_data_out),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr)
  );

  // Storage block model: indexed by the controller's pointer, registered read, not cleared by reset.
  logic [WIDTH-1:0] mem [0:3];
  assign stk_full  = (stk_pointer == 2'd2);
  assign stk_empty = (stk_pointer == 2'd0);
  always @(posedge clk) begin
    if (stk_push) mem[stk_pointer] <= stk_data_in;
    if (stk_pop)  stk_data_out <= mem[stk_pointer - 2'd1];
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       clr;
    logic       push;
    logic       pop;
    logic [1:0] ptr;
    logic       rsp;
    logic [7:0] rdata;
    logic       rerr;
    logic       ovf;
    logic       unf;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  vec_t vecs[13];
  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] data, input logic clr,
                              input logic push, input logic pop, input logic [1:0] ptr,
                              input logic rsp, input logic [7:0] rdata, input logic rerr,
                              input logic ovf, input logic unf);
    vec_t v;
    v.op = op; v.data = data; v.clr = clr; v.push = push; v.pop = pop; v.ptr = ptr;
    v.rsp = rsp; v.rdata = rdata; v.rerr = rerr; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic wait_rsp(input string tag, input int exp_lat);
    int   lat;
    rsp_t e;
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " busy"}, cmd_ready, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " rsp_data"}, rsp_data, e.data);
      chk({tag, " rsp_err"}, rsp_err, e.err);
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " rsp_done"}, rsp_valid, 0);
    chk({tag, " ready_back"}, cmd_ready, 1);
  endtask

  task automatic apply(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; err_clr = v.clr;
    #1;
    chk({t, " cmd_ready"}, cmd_ready, 1);
    chk({t, " stk_push"}, stk_push, v.push);
    chk({t, " stk_pop"}, stk_pop, v.pop);
    chk({t, " stk_data_in"}, stk_data_in, v.data);
    @(posedge clk); #1;
    cmd_valid = 1'b0; err_clr = 1'b0; cmd_op = 2'b00;
    chk({t, " ptr"}, stk_pointer, v.ptr);
    chk({t, " ovf"}, err_overflow, v.ovf);
    chk({t, " unf"}, err_underflow, v.unf);
    if (v.rsp) begin
      sb.push_back('{v.rdata, v.rerr});
      wait_rsp(t, v.rerr ? 0 : 1);
      handshake(t);
    end else begin
      chk({t, " no_rsp"}, rsp_valid, 0);
    end
  endtask

  task automatic simple(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00;
  endtask

  initial begin
    vecs[0]  = mk(2'b01, 8'hA5, 0, 1, 0, 2'd1, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(2'b01, 8'h3C, 0, 1, 0, 2'd2, 0, 8'h00, 0, 0, 0);
    vecs[2]  = mk(2'b01, 8'h77, 0, 0, 0, 2'd2, 0, 8'h00, 0, 1, 0);
    vecs[3]  = mk(2'b01, 8'h55, 1, 0, 0, 2'd2, 0, 8'h00, 0, 1, 0);
    vecs[4]  = mk(2'b00, 8'h00, 1, 0, 0, 2'd2, 0, 8'h00, 0, 0, 0);
    vecs[5]  = mk(2'b10, 8'h00, 0, 0, 1, 2'd1, 1, 8'h3C, 0, 0, 0);
    vecs[6]  = mk(2'b10, 8'h00, 0, 0, 1, 2'd0, 1, 8'hA5, 0, 0, 0);
    vecs[7]  = mk(2'b10, 8'h00, 0, 0, 0, 2'd0, 1, 8'h00, 1, 0, 1);
`ifdef STACK_CTRL_PEEK_EN
    vecs[8]  = mk(2'b11, 8'h00, 0, 0, 0, 2'd0, 1, 8'h00, 1, 0, 1);
    vecs[11] = mk(2'b11, 8'h00, 0, 0, 1, 2'd1, 1, 8'h11, 0, 0, 0);
`else
    vecs[8]  = mk(2'b11, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 1);
    vecs[11] = mk(2'b11, 8'h00, 0, 0, 0, 2'd1, 0, 8'h00, 0, 0, 0);
`endif
    vecs[9]  = mk(2'b00, 8'h00, 1, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0);
    vecs[10] = mk(2'b01, 8'h11, 0, 1, 0, 2'd1, 0, 8'h00, 0, 0, 0);
    vecs[12] = mk(2'b10, 8'h00, 0, 0, 1, 2'd0, 1, 8'h11, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst ptr", stk_pointer, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst ovf", err_overflow, 0);
    chk("rst unf", err_underflow, 0);
    rst = 1'b0;
    #1;
    chk("rst cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 13; i++) apply(i, vecs[i]);

    // Response held under backpressure for five cycles.
    simple(2'b01, 8'h42);
    chk("bp ptr_push", stk_pointer, 1);
    simple(2'b10, 8'h00);
    chk("bp ptr_pop", stk_pointer, 0);
    sb.push_back('{8'h42, 1'b0});
    wait_rsp("bp", 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d valid", k), rsp_valid, 1);
      chk($sformatf("bp%0d data", k), rsp_data, 8'h42);
      chk($sformatf("bp%0d err", k), rsp_err, 0);
      chk($sformatf("bp%0d cmd_ready", k), cmd_ready, 0);
    end
    handshake("bp");

    // Asynchronous reset while the controller is in CAPTURE.
    simple(2'b01, 8'h99);
    simple(2'b01, 8'h98);
    simple(2'b01, 8'h97);
    chk("ar ovf_set", err_overflow, 1);
    simple(2'b10, 8'h00);
    chk("ar ptr_pop", stk_pointer, 1);
    chk("ar capture", cmd_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("ar ptr", stk_pointer, 0);
    chk("ar rsp_valid", rsp_valid, 0);
    chk("ar rsp_data", rsp_data, 0);
    chk("ar ovf", err_overflow, 0);
    chk("ar cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ar%0d no_rsp", k), rsp_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
